apu_audio_out: RTL and testbench

Audio back-end for the APU. It consumes the 16-bit unsigned mixer output, `audio_out`, at the CPU rate. The sample is low-pass filtered by a one-pole IIR, converted to signed, and serialised as mono-duplicated 16-bit I2S at roughly 48 kHz for the board codec. It sits directly downstream of `apu` and is the only path from the APU to the pins.

---
 rtl/apu_audio_out_pkg.sv | 15 +
 rtl/apu_audio_out_i2s_tx.sv | 69 ++++++
 rtl/apu_audio_out.sv | 55 +++++
 tb/tb_apu_audio_out.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_audio_out_pkg.sv
// Shared APU audio constants and the offset-binary to two's-complement helper.
package apu_audio_out_pkg;

  localparam int I2S_SLOTS     = 32;
  localparam int I2S_WORD_BITS = 16;
  localparam int SLOT_W        = $clog2(I2S_SLOTS);

  // Flipping the MSB moves midscale 0x8000 onto signed zero.
  function automatic logic [I2S_WORD_BITS-1:0] to_signed_audio(
    input logic [I2S_WORD_BITS-1:0] y
  );
    return {~y[I2S_WORD_BITS-1], y[I2S_WORD_BITS-2:0]};
  endfunction

endpackage

// File: rtl/apu_audio_out_i2s_tx.sv
// I2S transmitter: BCLK divider, 32-slot frame counter, frame word latch and
// MSB-first shifter. Mono sample is duplicated into both channels.
module i2s_tx
  import apu_audio_out_pkg::*;
#(
  parameter int BCLK_DIV = 7
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [I2S_WORD_BITS-1:0] sample,
  input  logic                     mute,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  output logic                     sample_tick
);

  localparam int               DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]           div_cnt;
  logic [SLOT_W-1:0]          slot;
  logic [SLOT_W-1:0]          slot_nxt;
  logic [SLOT_W-1:0]          bit_idx;
  logic [2*I2S_WORD_BITS-1:0] word;
  logic                       div_tc;
  logic                       fall_evt;

  assign div_tc   = (div_cnt == DIV_TC);
  assign fall_evt = div_tc & i2s_bclk;
  assign slot_nxt = slot + SLOT_W'(1);
  // Slot n carries word[32-n]; the 5-bit negate gives exactly that for n = 1..31.
  assign bit_idx  = SLOT_W'(0) - slot_nxt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt     <= '0;
      i2s_bclk    <= 1'b0;
      slot        <= '1;
      word        <= '0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;

      if (div_tc) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (fall_evt) begin
        slot      <= slot_nxt;
        i2s_lrclk <= slot_nxt[SLOT_W-1];
        if (slot_nxt == '0) begin
          // Slot 0 still carries the previous frame's right-channel LSB.
          word        <= mute ? '0 : {sample, sample};
          i2s_sdata   <= word[0];
          sample_tick <= 1'b1;
        end else begin
          i2s_sdata <= word[bit_idx];
        end
      end
    end
  end

endmodule

// File: rtl/apu_audio_out.sv
// APU audio back-end: one-pole IIR low-pass on the CPU-rate mixer output,
// conversion to signed, and mono-duplicated 16-bit I2S to the board codec.
module apu_audio_out
  import apu_audio_out_pkg::*;
#(
  parameter int FILT_SHIFT = 4,
  parameter int BCLK_DIV   = 7
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     cpu_clk_en,
  input  logic [I2S_WORD_BITS-1:0] audio_in,
  input  logic                     mute,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  output logic                     sample_tick
);

  localparam int               ACC_W   = I2S_WORD_BITS + FILT_SHIFT;
  localparam logic [ACC_W-1:0] ACC_MID = ACC_W'(1) << (ACC_W - 1);

  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_nxt;
  logic [I2S_WORD_BITS-1:0] y;
  logic [I2S_WORD_BITS-1:0] sample;

  // acc - (acc >> K) never underflows and adding one 16-bit sample keeps the
  // result inside ACC_W bits, so the wider intermediate is not needed.
  assign acc_nxt = acc - (acc >> FILT_SHIFT) + ACC_W'(audio_in);
  assign y       = acc[ACC_W-1:FILT_SHIFT];
  assign sample  = to_signed_audio(y);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc <= ACC_MID;
    end else if (cpu_clk_en) begin
      acc <= acc_nxt;
    end
  end

  i2s_tx #(
    .BCLK_DIV (BCLK_DIV)
  ) u_i2s_tx (
    .clk         (clk),
    .rst_l       (rst_l),
    .sample      (sample),
    .mute        (mute),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .sample_tick (sample_tick)
  );

endmodule

// File: tb/tb_apu_audio_out.sv
// Self-checking bench for apu_audio_out: an arithmetic reference of the filter
// and the I2S frame timeline, driven with randomized and directed stimulus.
module tb_apu_audio_out;

  localparam int K     = 4;
  localparam int D     = 7;
  localparam int FRAME = 64 * D;

  logic        clk        = 1'b0;
  logic        rst_l      = 1'b1;
  logic        cpu_clk_en = 1'b0;
  logic        mute       = 1'b0;
  logic [15:0] audio_in   = 16'h8000;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_tick;

  apu_audio_out #(
    .FILT_SHIFT (K),
    .BCLK_DIV   (D)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .cpu_clk_en  (cpu_clk_en),
    .audio_in    (audio_in),
    .mute        (mute),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .sample_tick (sample_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: clk edges since reset release, filter accumulator,
  // current and previous frame words.
  int          k          = 0;
  longint      m_acc      = 64'h80000;
  logic [31:0] m_word     = 32'h0;
  logic [31:0] m_prev     = 32'h0;
  int          en_period  = 0;
  bit          rand_audio = 1'b0;

  function automatic int m_slot();
    return (31 + k / (2 * D)) % 32;
  endfunction

  function automatic logic [15:0] m_y();
    return 16'(m_acc >> K);
  endfunction

  function automatic logic [15:0] m_s(input logic [15:0] y);
    return y - 16'h8000;
  endfunction

  function automatic logic e_bclk();
    return ((k / D) % 2) == 1;
  endfunction

  function automatic logic e_lrclk();
    return (k >= 2 * D) && (m_slot() >= 16);
  endfunction

  function automatic logic e_tick();
    return (k > 0) && (k % (2 * D) == 0) && (m_slot() == 0);
  endfunction

  function automatic logic e_sdata();
    int n;
    n = m_slot();
    if (k < 2 * D) return 1'b0;
    if (n == 0) return m_prev[0];
    return m_word[5'(32 - n)];
  endfunction

  // Advance one clk edge and the reference model; returns 1 time unit after the edge.
  task automatic tick();
    logic [15:0] y_pre;
    @(posedge clk);
    y_pre = m_y();
    k++;
    if (e_tick()) begin
      m_prev = m_word;
      m_word = mute ? 32'h0 : {m_s(y_pre), m_s(y_pre)};
    end
    if (cpu_clk_en) m_acc = m_acc + audio_in - (m_acc >> K);
    #1;
    if (en_period > 0) cpu_clk_en = ((k + 1) % en_period) == 0;
    if (rand_audio) audio_in = 16'($urandom_range(0, 65535));
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    k      = 0;
    m_acc  = 64'h80000;
    m_word = 32'h0;
    m_prev = 32'h0;
    @(negedge clk);
    rst_l = 1'b1;
    if (en_period > 0) cpu_clk_en = (1 % en_period) == 0;
  endtask

  task automatic run_enables(input int n);
    cpu_clk_en = 1'b1;
    repeat (n) tick();
    cpu_clk_en = 1'b0;
  endtask

  // Wait for the next frame latch, then deserialise that frame from the pins.
  task automatic capture(output logic [31:0] got, output logic [31:0] exp);
    got = 32'h0;
    tick();
    while (!e_tick()) tick();
    exp = m_word;
    for (int n = 1; n <= 32; n++) begin
      repeat (2 * D) tick();
      got[5'(32 - n)] = i2s_sdata;
    end
  endtask

  task automatic test_reset();
    audio_in = 16'h8000; en_period = 12; rand_audio = 1'b0; mute = 1'b0;
    #2 rst_l = 1'b0;
    #1;
    total++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_tick} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_tick});
    end
    do_reset();
    for (int c = 0; c < 2 * FRAME + 2 * D; c++) begin
      tick();
      total++;
      if (i2s_sdata !== 1'b0) begin bad++; $display("FAIL reset_sdata k=%0d got=%b want=0", k, i2s_sdata); end
      total++;
      if (i2s_bclk !== e_bclk()) begin bad++; $display("FAIL reset_bclk k=%0d got=%b want=%b", k, i2s_bclk, e_bclk()); end
      total++;
      if (i2s_lrclk !== e_lrclk()) begin bad++; $display("FAIL reset_lrclk k=%0d got=%b want=%b", k, i2s_lrclk, e_lrclk()); end
      total++;
      if (sample_tick !== e_tick()) begin bad++; $display("FAIL reset_tick k=%0d got=%b want=%b", k, sample_tick, e_tick()); end
    end
  endtask

  task automatic test_framing();
    int   last_rise, last_tick, ticks, lr_rises;
    logic pb, pl;
    last_rise = -1; last_tick = -1; ticks = 0; lr_rises = 0;
    pb = i2s_bclk; pl = i2s_lrclk;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (i2s_bclk && !pb) begin
        if (last_rise >= 0) begin
          total++;
          if (k - last_rise != 2 * D) begin bad++; $display("FAIL bclk_period got=%0d want=%0d", k - last_rise, 2 * D); end
        end
        last_rise = k;
      end
      if (sample_tick) begin
        ticks++;
        if (last_tick >= 0) begin
          total++;
          if (k - last_tick != FRAME) begin bad++; $display("FAIL tick_period got=%0d want=%0d", k - last_tick, FRAME); end
        end
        last_tick = k;
      end
      if (i2s_lrclk && !pl) begin
        lr_rises++;
        total++;
        if ((k % (2 * D) != 0) || (m_slot() != 16)) begin
          bad++; $display("FAIL lrclk_rise k=%0d got_slot=%0d want_slot=16", k, m_slot());
        end
      end
      pb = i2s_bclk; pl = i2s_lrclk;
    end
    total++;
    if (ticks < 3) begin bad++; $display("FAIL tick_count got=%0d want>=3", ticks); end
    total++;
    if (lr_rises < 3) begin bad++; $display("FAIL lrclk_rise_count got=%0d want>=3", lr_rises); end
  endtask

  task automatic test_bit_order();
    logic [31:0] got, exp;
    en_period = 0; rand_audio = 1'b0;
    audio_in = 16'h9234;
    run_enables(400);
    for (int f = 0; f < 2; f++) begin
      capture(got, exp);
      total++;
      if (got !== 32'h12341234) begin bad++; $display("FAIL bit_order got=%h want=12341234", got); end
      total++;
      if (got !== exp) begin bad++; $display("FAIL bit_order_model got=%h want=%h", got, exp); end
    end
  endtask

  task automatic test_step();
    logic [31:0] got, exp;
    logic [15:0] last;
    en_period = 0; rand_audio = 1'b0; mute = 1'b0; cpu_clk_en = 1'b0;
    audio_in = 16'h8000;
    do_reset();
    audio_in = 16'hFFFF;
    run_enables(16);
    capture(got, exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL step_up16 got=%h want=%h", got, exp); end
    total++;
    if (got[31:16] < 16'h4F00 || got[31:16] > 16'h5400) begin
      bad++; $display("FAIL step_up16_band got=%h want=4f00..5400", got[31:16]);
    end
    last = got[31:16];
    for (int b = 0; b < 12; b++) begin
      run_enables(32);
      capture(got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL step_up_model got=%h want=%h", got, exp); end
      total++;
      if ($signed(got[31:16]) < $signed(last)) begin bad++; $display("FAIL step_up_monotonic got=%h want>=%h", got[31:16], last); end
      last = got[31:16];
    end
    total++;
    if (got !== 32'h7FFF7FFF) begin bad++; $display("FAIL step_up_final got=%h want=7fff7fff", got); end
    run_enables(64);
    capture(got, exp);
    total++;
    if (got !== 32'h7FFF7FFF) begin bad++; $display("FAIL step_up_hold got=%h want=7fff7fff", got); end

    audio_in = 16'h0000;
    run_enables(16);
    capture(got, exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL step_down16 got=%h want=%h", got, exp); end
    last = got[31:16];
    for (int b = 0; b < 12; b++) begin
      run_enables(32);
      capture(got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL step_down_model got=%h want=%h", got, exp); end
      total++;
      if ($signed(got[31:16]) > $signed(last)) begin bad++; $display("FAIL step_down_monotonic got=%h want<=%h", got[31:16], last); end
      last = got[31:16];
    end
    total++;
    if (got !== 32'h80008000) begin bad++; $display("FAIL step_down_final got=%h want=80008000", got); end
    run_enables(64);
    capture(got, exp);
    total++;
    if (got !== 32'h80008000) begin bad++; $display("FAIL step_down_hold got=%h want=80008000", got); end
  endtask

  task automatic test_mute();
    logic [31:0] w [3];
    logic [31:0] exp;
    int          n, f;
    en_period = 0; rand_audio = 1'b0; mute = 1'b0;
    audio_in = 16'h8000 ^ 16'($urandom_range(16'h0400, 16'h7FFF));
    run_enables(400);
    exp = {m_s(m_y()), m_s(m_y())};
    for (int i = 0; i < 3; i++) w[i] = 32'h0;
    tick();
    while (!e_tick()) tick();
    for (int ev = 1; ev <= 96; ev++) begin
      repeat (2 * D) tick();
      n = ev % 32;
      f = (ev - 1) / 32;
      w[f][5'(32 - n)] = i2s_sdata;
      if (ev == 8) mute = 1'b1;
      if (ev == 40) mute = 1'b0;
    end
    total++;
    if (w[0] !== exp) begin bad++; $display("FAIL mute_current_frame got=%h want=%h", w[0], exp); end
    total++;
    if (w[1] !== 32'h0) begin bad++; $display("FAIL mute_next_frame got=%h want=00000000", w[1]); end
    total++;
    if (w[2] !== exp) begin bad++; $display("FAIL mute_release got=%h want=%h", w[2], exp); end
  endtask

  task automatic test_random();
    en_period = 0; rand_audio = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      cpu_clk_en = ($urandom_range(0, 1) == 1) || (((k + 1 - 2 * D) % FRAME) == 0);
      mute = ($urandom_range(0, 199) == 0) ? ~mute : mute;
      total++;
      if (i2s_sdata !== e_sdata()) begin bad++; $display("FAIL rand_sdata k=%0d got=%b want=%b", k, i2s_sdata, e_sdata()); end
      total++;
      if (i2s_bclk !== e_bclk()) begin bad++; $display("FAIL rand_bclk k=%0d got=%b want=%b", k, i2s_bclk, e_bclk()); end
      total++;
      if (i2s_lrclk !== e_lrclk()) begin bad++; $display("FAIL rand_lrclk k=%0d got=%b want=%b", k, i2s_lrclk, e_lrclk()); end
      total++;
      if (sample_tick !== e_tick()) begin bad++; $display("FAIL rand_tick k=%0d got=%b want=%b", k, sample_tick, e_tick()); end
    end
    rand_audio = 1'b0; mute = 1'b0; cpu_clk_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int first_tick;
    tick();
    while (!((k % (2 * D) == 0) && (m_slot() == 20))) tick();
    total++;
    if (i2s_lrclk !== 1'b1) begin bad++; $display("FAIL slot20_lrclk got=%b want=1", i2s_lrclk); end
    #2 rst_l = 1'b0;
    #1;
    total++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_tick} !== 4'b0000) begin
      bad++; $display("FAIL async_reset got=%b want=0000", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_tick});
    end
    audio_in = 16'h8000; en_period = 12; rand_audio = 1'b0; mute = 1'b0;
    do_reset();
    first_tick = -1;
    for (int c = 0; c < FRAME + 4 * D; c++) begin
      tick();
      if (sample_tick && first_tick < 0) first_tick = k;
      total++;
      if (i2s_sdata !== e_sdata()) begin bad++; $display("FAIL rst2_sdata k=%0d got=%b want=%b", k, i2s_sdata, e_sdata()); end
      total++;
      if (i2s_bclk !== e_bclk()) begin bad++; $display("FAIL rst2_bclk k=%0d got=%b want=%b", k, i2s_bclk, e_bclk()); end
      total++;
      if (i2s_lrclk !== e_lrclk()) begin bad++; $display("FAIL rst2_lrclk k=%0d got=%b want=%b", k, i2s_lrclk, e_lrclk()); end
      total++;
      if (sample_tick !== e_tick()) begin bad++; $display("FAIL rst2_tick k=%0d got=%b want=%b", k, sample_tick, e_tick()); end
    end
    total++;
    if (first_tick != 2 * D) begin bad++; $display("FAIL rst2_first_tick got=%0d want=%0d", first_tick, 2 * D); end
  endtask

  initial begin
    test_reset();
    test_framing();
    test_bit_order();
    test_step();
    test_mute();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
